// File: rtl/contador.sv
// contador: synchronised, edge-detected event counter with saturation and BCD display outputs.
// Optional debounce filter enabled by defining CONTADOR_DEBOUNCE_EN.
`default_nettype none

module contador #(
  parameter int WIDTH      = 8,
  parameter int MAX_COUNT  = 99,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cuenta,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             full,
  output logic [3:0]       bcd_u,
  output logic [3:0]       bcd_d
);

  logic       sync1;
  logic       sync2;
  logic [1:0] vld;
  logic       lvl;
  logic       prev;
  logic       armed;
  logic       rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld   <= 2'b00;
    end else begin
      sync1 <= cuenta;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
    end
  end

`ifdef CONTADOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt;
  logic          filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync2 != filt) begin
      if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        filt    <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign lvl = filt;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = |DEB_CYCLES;
  assign lvl = sync2;
`endif

  // A level held high through reset must not count: arm only once a genuine low is seen.
  assign rise = lvl & ~prev & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      count <= '0;
      evt   <= 1'b0;
      full  <= 1'b0;
    end else begin
      prev  <= lvl;
      armed <= armed | (vld[1] & ~sync2);
      evt   <= 1'b0;
      if (rise && (count != WIDTH'(MAX_COUNT))) begin
        count <= count + WIDTH'(1);
        evt   <= 1'b1;
        full  <= ((count + WIDTH'(1)) == WIDTH'(MAX_COUNT));
      end
    end
  end

  always_comb begin
    bcd_u = 4'(count % WIDTH'(10));
    bcd_d = ((count / WIDTH'(10)) > WIDTH'(9)) ? 4'd9 : 4'(count / WIDTH'(10));
  end

endmodule

`default_nettype wire

// File: tb/tb_contador.sv
// tb_contador: directed self-checking bench for contador (timing, saturation, reset behaviour).
`default_nettype none

module tb_contador;

`ifdef CONTADOR_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam int HI  = 6;
  localparam int LO  = 6;
`else
  localparam int LAT = 3;
  localparam int HI  = 3;
  localparam int LO  = 3;
`endif

  logic       clk;
  logic       rst_n;
  logic       cuenta;
  logic [7:0] count;
  logic       evt;
  logic       full;
  logic [3:0] bcd_u;
  logic [3:0] bcd_d;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int evt_seen  = 0;
  int exp_count = 0;

  contador #(.WIDTH(8), .MAX_COUNT(99), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cuenta(cuenta),
    .count (count),
    .evt   (evt),
    .full  (full),
    .bcd_u (bcd_u),
    .bcd_d (bcd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (evt === 1'b1) evt_seen++;

  task automatic do_reset();
    rst_n = 1'b0;
    cuenta = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_count = 0;
  endtask

  task automatic pulse(input int hi, input int lo);
    cuenta = 1'b1;
    repeat (hi) @(negedge clk);
    cuenta = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cuenta = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (count !== 8'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (evt !== 1'b0) $display("FAIL reset_evt got %b want 0", evt); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
    total_cnt++; if (bcd_u !== 4'd0) $display("FAIL reset_bcd_u got %0d want 0", bcd_u); else pass_cnt++;
    total_cnt++; if (bcd_d !== 4'd0) $display("FAIL reset_bcd_d got %0d want 0", bcd_d); else pass_cnt++;
    repeat (2) @(negedge clk);
    exp_count = 0;
  endtask

  // Rise set just after a negedge is first sampled at the next posedge (edge k);
  // the increment must appear after edge k+LAT-1, i.e. at the LAT-th negedge.
  task automatic timed_pulse(input string name);
    cuenta = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      if (i == HI) cuenta = 1'b0;
      if (i == LAT - 1) begin
        total_cnt++; if (evt !== 1'b0 || count !== 8'(exp_count))
          $display("FAIL %s_early got evt=%b count=%0d want evt=0 count=%0d", name, evt, count, exp_count);
        else pass_cnt++;
      end
      if (i == LAT) begin
        exp_count++;
        total_cnt++; if (evt !== 1'b1 || count !== 8'(exp_count))
          $display("FAIL %s_on_time got evt=%b count=%0d want evt=1 count=%0d", name, evt, count, exp_count);
        else pass_cnt++;
      end
      if (i == LAT + 1) begin
        total_cnt++; if (evt !== 1'b0) $display("FAIL %s_one_cycle got evt=%b want 0", name, evt); else pass_cnt++;
      end
    end
    cuenta = 1'b0;
    repeat (LO) @(negedge clk);
  endtask

  task automatic test_two_pulses();
    int e0;
    do_reset();
    e0 = evt_seen;
    timed_pulse("pulse1");
    timed_pulse("pulse2");
    repeat (4) @(negedge clk);
    total_cnt++; if (count !== 8'd2) $display("FAIL two_pulses_count got %0d want 2", count); else pass_cnt++;
    total_cnt++; if (evt_seen - e0 !== 2) $display("FAIL two_pulses_strobes got %0d want 2", evt_seen - e0); else pass_cnt++;
  endtask

`ifdef CONTADOR_DEBOUNCE_EN
  task automatic test_debounce();
    int e0;
    do_reset();
    e0 = evt_seen;
    pulse(2, 12);
    total_cnt++; if (count !== 8'd0) $display("FAIL glitch_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (evt_seen !== e0) $display("FAIL glitch_evt got %0d want 0", evt_seen - e0); else pass_cnt++;
    timed_pulse("deb_pulse");
  endtask
`endif

  task automatic test_saturation();
    int e0;
    do_reset();
    e0 = evt_seen;
    repeat (42) pulse(HI, LO);
    total_cnt++; if (bcd_d !== 4'd4 || bcd_u !== 4'd2)
      $display("FAIL bcd_42 got %0d%0d want 42", bcd_d, bcd_u); else pass_cnt++;
    repeat (56) pulse(HI, LO);
    total_cnt++; if (count !== 8'd98 || full !== 1'b0)
      $display("FAIL count_98 got count=%0d full=%b want 98/0", count, full); else pass_cnt++;
    pulse(HI, LO);
    total_cnt++; if (count !== 8'd99 || full !== 1'b1)
      $display("FAIL count_99 got count=%0d full=%b want 99/1", count, full); else pass_cnt++;
    total_cnt++; if (bcd_d !== 4'd9 || bcd_u !== 4'd9)
      $display("FAIL bcd_99 got %0d%0d want 99", bcd_d, bcd_u); else pass_cnt++;
    total_cnt++; if (evt_seen - e0 !== 99) $display("FAIL strobes_99 got %0d want 99", evt_seen - e0); else pass_cnt++;
    pulse(HI, LO);
    total_cnt++; if (count !== 8'd99 || full !== 1'b1)
      $display("FAIL saturate got count=%0d full=%b want 99/1", count, full); else pass_cnt++;
    total_cnt++; if (evt_seen - e0 !== 99) $display("FAIL no_evt_at_max got %0d want 99", evt_seen - e0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    int e0;
    do_reset();
    repeat (5) pulse(HI, LO);
    total_cnt++; if (count !== 8'd5 || bcd_u !== 4'd5 || bcd_d !== 4'd0)
      $display("FAIL pre_reset got count=%0d bcd=%0d%0d want 5/05", count, bcd_d, bcd_u); else pass_cnt++;
    cuenta = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (count !== 8'd0 || full !== 1'b0 || evt !== 1'b0)
      $display("FAIL async_clear got count=%0d full=%b evt=%b want 0/0/0", count, full, evt); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = evt_seen;
    repeat (12) @(negedge clk);
    total_cnt++; if (count !== 8'd0 || evt_seen !== e0)
      $display("FAIL held_after_mid_reset got count=%0d strobes=%0d want 0/0", count, evt_seen - e0); else pass_cnt++;
    cuenta = 1'b0;
    repeat (LO) @(negedge clk);
    pulse(HI, LO);
    total_cnt++; if (count !== 8'd1) $display("FAIL count_after_mid_reset got %0d want 1", count); else pass_cnt++;
  endtask

  task automatic test_held_across_reset();
    rst_n = 1'b0;
    cuenta = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    total_cnt++; if (count !== 8'd0 || evt !== 1'b0)
      $display("FAIL held_release got count=%0d evt=%b want 0/0", count, evt); else pass_cnt++;
    cuenta = 1'b0;
    repeat (LO) @(negedge clk);
    total_cnt++; if (count !== 8'd0) $display("FAIL held_fall got %0d want 0", count); else pass_cnt++;
    pulse(HI, LO);
    total_cnt++; if (count !== 8'd1) $display("FAIL held_next_rise got %0d want 1", count); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    cuenta = 1'b0;
    test_reset();
    test_two_pulses();
`ifdef CONTADOR_DEBOUNCE_EN
    test_debounce();
`endif
    test_saturation();
    test_reset_mid_pulse();
    test_held_across_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
